// File: rtl/sdram_clk_supervisor.sv
// SDRAM rPLL sequencer: holds the PLL in reset, waits for lock with a timeout,
// qualifies it as stable, then releases the SDRAM-domain reset. Lock loss is retried and eventually latched as a fault.
module sdram_clk_supervisor #(
    parameter int RST_CYCLES    = 24,
    parameter int LOCK_TIMEOUT  = 2400,
    parameter int STABLE_CYCLES = 240,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sdram_rst,
    output logic       clk_ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             lock_m, lock_s;
    logic             lost_nxt;
    logic             fail;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        lost_nxt  = 1'b0;
        fail      = 1'b0;
        // A relock request outranks a coincident timeout or lock drop.
        if (relock_req && (state inside {WAIT_LOCK, STABLE, RUN})) begin
            state_nxt = RST_PLL;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RST_PLL: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT_LOCK;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        cnt_nxt   = '0;
                        state_nxt = STABLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        fail = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE: begin
                    // A glitch just restarts the lock wait; it is not a failure.
                    if (!lock_s) begin
                        cnt_nxt   = '0;
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        lost_nxt = 1'b1;
                        fail     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (fail) begin
            cnt_nxt = '0;
            if (retry_cnt < 2'(MAX_RETRY - 1)) begin
                retry_nxt = retry_cnt + 2'd1;
                state_nxt = RST_PLL;
            end else begin
                retry_nxt = 2'(MAX_RETRY);
                state_nxt = FAULT;
            end
        end
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_PLL;
            cnt       <= '0;
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            pll_reset <= 1'b1;
            sdram_rst <= 1'b1;
            clk_ready <= 1'b0;
            fault     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            pll_reset <= (state_nxt == RST_PLL) || (state_nxt == FAULT);
            sdram_rst <= (state_nxt != RUN);
            clk_ready <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
            lock_lost <= lost_nxt;
            retry_cnt <= retry_nxt;
        end
    end

endmodule

// File: doc/sdram_clk_supervisor.md
Name: sdram_clk_supervisor

Overview:
Sequences the SDRAM rPLL: holds the PLL in reset, waits for lock with a timeout, and qualifies lock as stable. It releases the SDRAM-domain reset only once lock is qualified. It also detects loss of lock, retries up to a bounded count, and then latches a fault. It runs on the 24 MHz board clock that also feeds the PLL CLKIN, never on a PLL output.

Parameters:
RST_CYCLES, 24, cycles pll_reset is held high per attempt (1 us at 24 MHz)
LOCK_TIMEOUT, 2400, max cycles in WAIT_LOCK before the attempt fails (100 us)
STABLE_CYCLES, 240, consecutive synchronized-lock-high cycles required to qualify lock (10 us)
MAX_RETRY, 3, failed attempts tolerated before FAULT
CNT_W, 12, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
clk  input  1  24 MHz reference clock (same net as PLL clkin)
rst  input  1  synchronous reset, active-high
pll_lock  input  1  PLL lock output; asynchronous to clk
relock_req  input  1  single-cycle request to force a full PLL restart
pll_reset  output  1  drives PLL RESET and RESET_P
sdram_rst  output  1  active-high reset for the SDRAM controller domain
clk_ready  output  1  high while in RUN
fault  output  1  sticky; high in FAULT
lock_lost  output  1  one-cycle pulse when lock drops during RUN
retry_cnt  output  2  number of failed attempts since rst, saturating at MAX_RETRY

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values (cycle after rst is sampled high): state=RST_PLL, counter=0, pll_reset=1, sdram_rst=1, clk_ready=0, fault=0, lock_lost=0, retry_cnt=0, synchronizer flops=0.
- Lock synchronizer: pll_lock passes through 2 flops to give lock_s. All decisions use lock_s only, so lock has 2 cycles of latency.
- RST_PLL:
  - pll_reset=1, sdram_rst=1.
  - The counter increments each cycle.
  - When counter==RST_CYCLES-1: clear the counter and go to WAIT_LOCK.
  - pll_reset is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_reset=0, sdram_rst=1.
  - If lock_s=1: clear the counter and go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1: the attempt fails (see Failure).
  - Else increment the counter.
- STABLE:
  - pll_reset=0, sdram_rst=1.
  - If lock_s=0: clear the counter and return to WAIT_LOCK. This is a glitch, not a failure; the timeout restarts.
  - Else if counter==STABLE_CYCLES-1: go to RUN.
  - Else increment the counter.
- RUN:
  - pll_reset=0, sdram_rst=0, clk_ready=1.
  - If lock_s falls to 0: lock_lost pulses for 1 cycle, sdram_rst and clk_ready change on the same edge that leaves RUN, and the attempt fails.
- Failure:
  - If retry_cnt < MAX_RETRY-1: retry_cnt increments, the counter clears, and the state goes to RST_PLL.
  - If retry_cnt == MAX_RETRY-1: retry_cnt becomes MAX_RETRY, the state goes to FAULT, and fault=1.
- FAULT:
  - pll_reset=1, sdram_rst=1, clk_ready=0.
  - Only rst exits FAULT; relock_req is ignored here.
- relock_req:
  - Sampled in WAIT_LOCK, STABLE and RUN; ignored in RST_PLL.
  - It forces RST_PLL with the counter cleared and does not change retry_cnt.
  - In RUN it does not pulse lock_lost.
  - If it coincides with a timeout or a lock drop, relock_req wins: no retry is counted and there is no lock_lost pulse.
- retry_cnt is never cleared by a successful lock; it clears only on rst.
- Reset mid-operation: rst overrides every state on the same edge. It re-applies the reset values, so pll_reset reasserts and sdram_rst stays high.
- No combinational path from any input to any output; all outputs are registered.
- sdram_rst is synchronous to clk. The SDRAM domain re-synchronizes it (not this block's job).

Test Plan:
Sim parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3.
- Nominal bring-up: rst 2 cycles; pll_lock rises 6 cycles after pll_reset falls and stays high -> pll_reset high exactly 4 cycles; clk_ready and sdram_rst=0 exactly 2+8 cycles after pll_lock rises; retry_cnt=0.
- Lock glitch in STABLE: lock high 5 cycles, low 1 cycle, then high -> return to WAIT_LOCK; clk_ready first rises 10 cycles after the final rise; no pll_reset pulse; retry_cnt=0.
- Lock loss in RUN: drop pll_lock once in RUN -> lock_lost is a single pulse 2 cycles later; sdram_rst=1 and pll_reset=1 for 4 cycles; retry_cnt=1; relock completes normally.
- Timeout to fault: pll_lock held 0 -> three attempts, each 4 reset cycles + 20 wait cycles; retry_cnt steps 1, 2, 3; fault=1 and pll_reset stays 1; a later pll_lock=1 or relock_req causes no change.
- relock_req in RUN coinciding with a lock drop -> RST_PLL entered, no lock_lost pulse, retry_cnt unchanged.
- rst asserted mid-STABLE and mid-FAULT -> next cycle all outputs equal their reset values; fault and retry_cnt clear.
